// File: rtl/gbsha_ser_pkg.sv
// ---------------------------------------------------------------------------
// gbsha_ser_pkg
// Shared types and helpers for the sample serializer slice.
//   ser_state_e : frame FSM states
//   beats()     : number of lane beats needed for one sample (ceiling division)
//   cnt_width() : width of the shared beat/gap down-counter
// ---------------------------------------------------------------------------
package gbsha_ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        GAP  = 2'd3
    } ser_state_e;

    function automatic int beats(input int bw_sample, input int bw_lane);
        return (bw_sample + bw_lane - 1) / bw_lane;
    endfunction

    // The counter must hold the larger of BEATS and GAP_CYCLES; never narrower than 1 bit.
    function automatic int cnt_width(input int n_beats, input int gap_cycles);
        int m;
        m = (n_beats > gap_cycles) ? n_beats : gap_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/gbsha_beat_counter.sv
// ---------------------------------------------------------------------------
// gbsha_beat_counter
// Loadable down-counter with terminal-count flag, shared by the DATA and GAP
// phases of the serializer.
//   clk        in   clock
//   reset      in   asynchronous, active-high; clears the count
//   load_i     in   load load_val_i (has priority over decrement)
//   load_val_i in   W  value to load
//   dec_i      in   decrement by one (saturates at zero)
//   tc_o       out  count is zero
// ---------------------------------------------------------------------------
module gbsha_beat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/gbsha_sample_serializer.sv
// ---------------------------------------------------------------------------
// gbsha_sample_serializer
// Accepts one BW_SAMPLE-wide sample per valid/ready handshake and sends it
// LSB-first on a BW_LANE-wide registered pin lane, with a frame strobe on the
// first beat, followed by GAP_CYCLES idle beats (lane held 0).
//
// Build option: define SER_PARITY_EN to append one even-parity beat
// (lane_out[0] = XOR of the sample, upper lane bits 0) after the data beats.
//
// Ports
//   clk       in   single clock, posedge
//   reset     in   asynchronous, active-high
//   s_data    in   BW_SAMPLE  sample, taken when s_valid && s_ready
//   s_valid   in   source has a sample
//   s_ready   out  high only in IDLE and not in reset
//   lane_out  out  BW_LANE    registered serial lane
//   frame     out  registered, high on beat 0 only
//   busy      out  state != IDLE
//
// state | meaning
// IDLE  | waiting for a sample, lane 0, s_ready high
// DATA  | lane shows data beats 0..BEATS-1
// PAR   | lane shows the even-parity beat (SER_PARITY_EN only)
// GAP   | lane held 0 for GAP_CYCLES beats
// ---------------------------------------------------------------------------
module gbsha_sample_serializer
    import gbsha_ser_pkg::*;
#(
    parameter int BW_SAMPLE  = 8,
    parameter int BW_LANE    = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BW_SAMPLE-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [BW_LANE-1:0]   lane_out,
    output logic                 frame,
    output logic                 busy
);

    localparam int BEATS = beats(BW_SAMPLE, BW_LANE);
    localparam int PW    = BEATS * BW_LANE;
    localparam int CW    = cnt_width(BEATS, GAP_CYCLES);

    localparam logic [CW-1:0] LOAD_DATA = CW'(BEATS - 1);
    localparam logic [CW-1:0] LOAD_GAP  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ser_state_e         state_q, state_d;
    logic [PW-1:0]      shift_q, shift_d;
    logic [BW_LANE-1:0] lane_q, lane_d;
    logic               frame_q, frame_d;
    logic [PW-1:0]      pad_w;

    logic               cnt_load;
    logic [CW-1:0]      cnt_val;
    logic               cnt_dec;
    logic               cnt_tc;

`ifdef SER_PARITY_EN
    logic               parity_q;
`endif

    // Sample zero-padded at the MSB end so the last beat is always full width.
    always_comb begin
        pad_w                = '0;
        pad_w[BW_SAMPLE-1:0] = s_data;
    end

    gbsha_beat_counter #(
        .W (CW)
    ) u_beat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .tc_o       (cnt_tc)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s_valid) state_d = DATA;
            end
            DATA: begin
                if (cnt_tc) begin
`ifdef SER_PARITY_EN
                    state_d = PAR;
`else
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
`endif
                end
            end
            PAR: begin
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (cnt_tc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic. lane and frame are computed one cycle ahead and
    // registered, so the value shown during a state is set on the edge entering it.
    always_comb begin
        shift_d  = shift_q;
        lane_d   = '0;
        frame_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = LOAD_DATA;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    lane_d   = pad_w[BW_LANE-1:0];
                    shift_d  = pad_w >> BW_LANE;
                    frame_d  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = LOAD_DATA;
                end
            end
            DATA: begin
                if (cnt_tc) begin
`ifdef SER_PARITY_EN
                    lane_d[0] = parity_q;
`endif
                    cnt_load = 1'b1;
                    cnt_val  = LOAD_GAP;
                end else begin
                    lane_d  = shift_q[BW_LANE-1:0];
                    shift_d = shift_q >> BW_LANE;
                    cnt_dec = 1'b1;
                end
            end
            PAR: begin
                cnt_load = 1'b1;
                cnt_val  = LOAD_GAP;
            end
            GAP: begin
                cnt_dec = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            lane_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            lane_q  <= lane_d;
            frame_q <= frame_d;
        end
    end

`ifdef SER_PARITY_EN
    // Parity is taken from the sample at capture; the shift register loses bits as it drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if ((state_q == IDLE) && s_valid) begin
            parity_q <= ^s_data;
        end
    end
`endif

    // reset gates s_ready directly: the state flop already reads IDLE while reset is high.
    assign s_ready  = (state_q == IDLE) && !reset;
    assign busy     = (state_q != IDLE);
    assign lane_out = lane_q;
    assign frame    = frame_q;

endmodule

// File: tb/tb_gbsha_sample_serializer.sv
module tb_gbsha_sample_serializer;

`ifdef SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sd0, sd2;
    logic [4:0] sd1;
    logic [2:0] sv;
    logic [2:0] rdy, frm, bsy;
    logic [1:0] lo0, lo1;
    logic [0:0] lo2;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gbsha_sample_serializer #(.BW_SAMPLE(8), .BW_LANE(2), .GAP_CYCLES(1)) u0 (
        .clk(clk), .reset(reset), .s_data(sd0), .s_valid(sv[0]), .s_ready(rdy[0]),
        .lane_out(lo0), .frame(frm[0]), .busy(bsy[0]));
    gbsha_sample_serializer #(.BW_SAMPLE(5), .BW_LANE(2), .GAP_CYCLES(2)) u1 (
        .clk(clk), .reset(reset), .s_data(sd1), .s_valid(sv[1]), .s_ready(rdy[1]),
        .lane_out(lo1), .frame(frm[1]), .busy(bsy[1]));
    gbsha_sample_serializer #(.BW_SAMPLE(8), .BW_LANE(1), .GAP_CYCLES(0)) u2 (
        .clk(clk), .reset(reset), .s_data(sd2), .s_valid(sv[2]), .s_ready(rdy[2]),
        .lane_out(lo2), .frame(frm[2]), .busy(bsy[2]));

    function automatic int cfg_bw(input int i);
        return (i == 1) ? 5 : 8;
    endfunction
    function automatic int cfg_lane(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic int cfg_gap(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 0);
    endfunction

    function automatic int get_lane(input int i);
        case (i)
            0:       return int'(lo0);
            1:       return int'(lo1);
            default: return int'(lo2);
        endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input int i, input logic [7:0] d, input logic v);
        case (i)
            0:       begin sd0 = d;      sv[0] = v; end
            1:       begin sd1 = d[4:0]; sv[1] = v; end
            default: begin sd2 = d;      sv[2] = v; end
        endcase
    endtask

    task automatic chk_idle(input int i);
        chk("idle_ready", int'(rdy[i]), 1);
        chk("idle_busy",  int'(bsy[i]), 0);
        chk("idle_lane",  get_lane(i), 0);
        chk("idle_frame", int'(frm[i]), 0);
    endtask

    task automatic idle(input int i, input int n);
        for (int c = 0; c < n; c++) begin
            set_in(i, 8'($urandom), 1'b0);
            #1 chk_idle(i);
            @(negedge clk);
        end
    endtask

    // Called at a negedge with DUT i in IDLE; returns at the negedge of the next IDLE cycle.
    task automatic send(input int i, input logic [7:0] d);
        int bw, bl, nb, g, expv, len;
        int dm;
        bw  = cfg_bw(i);
        bl  = cfg_lane(i);
        g   = cfg_gap(i);
        nb  = (bw + bl - 1) / bl;
        dm  = int'(d) & ((1 << bw) - 1);
        len = nb + P + g;
        set_in(i, d, 1'b1);
        #1 chk_idle(i);
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) last_start = cyc;
            set_in(i, 8'($urandom), 1'($urandom));
            if (k < nb)          expv = (dm >> (k * bl)) & ((1 << bl) - 1);
            else if (k < nb + P) expv = $countones(dm) % 2;
            else                 expv = 0;
            chk("lane",  get_lane(i), expv);
            chk("frame", int'(frm[i]), (k == 0) ? 1 : 0);
            chk("ready", int'(rdy[i]), 0);
            chk("busy",  int'(bsy[i]), 1);
        end
        @(negedge clk);
        set_in(i, 8'h00, 1'b0);
    endtask

    initial begin
        int s1, idx;
        logic [7:0] d;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) set_in(i, 8'($urandom), 1'b1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", int'(rdy[i]), 0);
            chk("rst_lane",  get_lane(i), 0);
            chk("rst_frame", int'(frm[i]), 0);
            chk("rst_busy",  int'(bsy[i]), 0);
        end
        for (int i = 0; i < 3; i++) set_in(i, 8'h00, 1'b0);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("rel_ready", int'(rdy[i]), 1);
        @(negedge clk);

        send(0, 8'hB5);
        send(0, 8'hB4);
        idle(0, 2);
        send(1, 8'h17);
        idle(1, 1);

        send(2, 8'h01);
        s1 = last_start;
        send(2, 8'h80);
        chk("b2b_period", last_start - s1, 1 + 8 + P);
        idle(2, 1);

        set_in(2, 8'hFF, 1'b1);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_in(2, 8'h00, 1'b0);
        end
        chk("mid_beat3_lane", get_lane(2), 1);
        chk("mid_beat3_busy", int'(bsy[2]), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_lane",  get_lane(2), 0);
        chk("mid_rst_frame", int'(frm[2]), 0);
        chk("mid_rst_busy",  int'(bsy[2]), 0);
        chk("mid_rst_ready", int'(rdy[2]), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(2, 8'hA5);

        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 2));
            d   = 8'($urandom);
            if ($urandom_range(0, 1) == 1) idle(idx, int'($urandom_range(1, 3)));
            send(idx, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
